// File: rtl/pwm_multi_ch_pkg.sv
// Shared types and helpers for the multi-channel PWM block (package pwm_pkg).
// Holds the counter direction type, the saturating duty update and the duty_out lane helper.
package pwm_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Saturating duty update: clamps at period on increment and at 0 on decrement.
  // Simultaneous inc and dec cancel out.
  function automatic int duty_step(input int cur, input logic inc, input logic dec,
                                   input int step, input int period);
    int res;
    res = cur;
    if (inc && !dec) begin
      res = (cur + step > period) ? period : cur + step;
    end else if (dec && !inc) begin
      res = (cur >= step) ? cur - step : 0;
    end
    return res;
  endfunction

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/pwm_multi_ch_debounce.sv
// Button debouncer (module pwm_debounce): two slow-enable sampled FFs and
// a single-cycle rising-edge press pulse.
module pwm_debounce (
  input  logic clk,
  input  logic rst,
  input  logic slow_en,
  input  logic btn,
  output logic press
);

  logic q1;
  logic q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
    end else if (slow_en) begin
      q1 <= btn;
      q2 <= q1;
    end
  end

  assign press = q1 & ~q2 & slow_en;

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator with per-channel debounced duty buttons and shadowed duty.
// Define PWM_CENTER_ALIGN_EN for center-aligned (up/down) counting; default is edge-aligned.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int CNT_W      = 4,
  parameter int PERIOD     = 10,
  parameter int STEP       = 1,
  parameter int DUTY_RESET = 5,
  parameter int DEB_DIV    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       inc_btn,
  input  logic [CHANNELS-1:0]       dec_btn,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic [CHANNELS*CNT_W-1:0] duty_out,
  output logic                      period_start
);

  localparam int DIV_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DEB_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] DUTY_INIT = CNT_W'(DUTY_RESET);

  logic [DIV_W-1:0]    div;
  logic                slow_en;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                load;
  logic [CHANNELS-1:0] inc_press;
  logic [CHANNELS-1:0] dec_press;
  logic [CNT_W-1:0]    duty_target [CHANNELS];
  logic [CNT_W-1:0]    duty_active [CHANNELS];

  // Debounce sample divider, free-running regardless of en
  assign slow_en = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst || slow_en) div <= '0;
    else                div <= div + DIV_W'(1);
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    pwm_debounce u_deb_inc (
      .clk     (clk),
      .rst     (rst),
      .slow_en (slow_en),
      .btn     (inc_btn[g]),
      .press   (inc_press[g])
    );
    pwm_debounce u_deb_dec (
      .clk     (clk),
      .rst     (rst),
      .slow_en (slow_en),
      .btn     (dec_btn[g]),
      .press   (dec_press[g])
    );
    assign duty_out[lane_lsb(g, CNT_W) +: CNT_W] = duty_active[g];
  end

`ifdef PWM_CENTER_ALIGN_EN
  dir_e dir;
  dir_e dir_nxt;

  always_ff @(posedge clk) begin
    if (rst) dir <= DIR_UP;
    else     dir <= dir_nxt;
  end

  // Up/down count; the shadow load happens only when turning from DOWN to UP at 0
  always_comb begin
    dir_nxt = dir;
    cnt_nxt = cnt;
    load    = 1'b0;
    if (en) begin
      case (dir)
        DIR_UP: begin
          if (cnt == CNT_LAST) dir_nxt = DIR_DOWN;
          else                 cnt_nxt = cnt + CNT_W'(1);
        end
        DIR_DOWN: begin
          if (cnt == '0) begin
            dir_nxt = DIR_UP;
            load    = 1'b1;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        default: dir_nxt = DIR_UP;
      endcase
    end
  end
`else
  always_comb begin
    cnt_nxt = cnt;
    load    = 1'b0;
    if (en) begin
      if (cnt == CNT_LAST) begin
        cnt_nxt = '0;
        load    = 1'b1;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      period_start <= 1'b0;
      pwm_out      <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_target[i] <= DUTY_INIT;
        duty_active[i] <= DUTY_INIT;
      end
    end else begin
      cnt          <= cnt_nxt;
      period_start <= load;
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_out[i]     <= en & (cnt < duty_active[i]);
        duty_target[i] <= CNT_W'(duty_step(int'(duty_target[i]), inc_press[i],
                                           dec_press[i], STEP, PERIOD));
        if (load) duty_active[i] <= duty_target[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Randomized self-checking bench for pwm_multi_ch against a phase-based reference model.
// Model follows PWM_CENTER_ALIGN_EN when the macro is defined.
module tb_pwm_multi_ch;

  localparam int CHANNELS   = 2;
  localparam int CNT_W      = 4;
  localparam int PERIOD     = 10;
  localparam int STEP       = 1;
  localparam int DUTY_RESET = 5;
  localparam int DEB_DIV    = 2;
`ifdef PWM_CENTER_ALIGN_EN
  localparam int PLEN = 2 * PERIOD;
`else
  localparam int PLEN = PERIOD;
`endif

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      en;
  logic [CHANNELS-1:0]       inc_btn;
  logic [CHANNELS-1:0]       dec_btn;
  logic [CHANNELS-1:0]       pwm_out;
  logic [CHANNELS*CNT_W-1:0] duty_out;
  logic                      period_start;

  pwm_multi_ch #(
    .CHANNELS(CHANNELS), .CNT_W(CNT_W), .PERIOD(PERIOD),
    .STEP(STEP), .DUTY_RESET(DUTY_RESET), .DEB_DIV(DEB_DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .inc_btn      (inc_btn),
    .dec_btn      (dec_btn),
    .pwm_out      (pwm_out),
    .duty_out     (duty_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int   m_phase;
  int   m_tick;
  int   m_target [CHANNELS];
  int   m_active [CHANNELS];
  bit   m_pwm    [CHANNELS];
  bit   m_ps;
  bit   m_inc_s1 [CHANNELS];
  bit   m_inc_s2 [CHANNELS];
  bit   m_dec_s1 [CHANNELS];
  bit   m_dec_s2 [CHANNELS];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int phase_cnt(input int ph);
    return (ph < PERIOD) ? ph : (2 * PERIOD - 1 - ph);
  endfunction

  function automatic logic [CHANNELS*CNT_W-1:0] exp_duty();
    logic [CHANNELS*CNT_W-1:0] v;
    v = '0;
    for (int i = 0; i < CHANNELS; i++) v[i*CNT_W +: CNT_W] = CNT_W'(m_active[i]);
    return v;
  endfunction

  function automatic logic [CHANNELS-1:0] exp_pwm();
    logic [CHANNELS-1:0] v;
    for (int i = 0; i < CHANNELS; i++) v[i] = m_pwm[i];
    return v;
  endfunction

  task automatic model_step();
    bit ip;
    bit dp;
    if (rst) begin
      m_phase = 0; m_tick = 0; m_ps = 0;
      for (int i = 0; i < CHANNELS; i++) begin
        m_target[i] = DUTY_RESET; m_active[i] = DUTY_RESET; m_pwm[i] = 0;
        m_inc_s1[i] = 0; m_inc_s2[i] = 0; m_dec_s1[i] = 0; m_dec_s2[i] = 0;
      end
      return;
    end
    for (int i = 0; i < CHANNELS; i++)
      m_pwm[i] = en && (phase_cnt(m_phase) < m_active[i]);
    m_ps = 0;
    if (en) begin
      m_phase = (m_phase + 1) % PLEN;
      if (m_phase == 0) begin
        m_ps = 1;
        for (int i = 0; i < CHANNELS; i++) m_active[i] = m_target[i];
      end
    end
    if (m_tick == DEB_DIV - 1) begin
      for (int i = 0; i < CHANNELS; i++) begin
        ip = m_inc_s1[i] && !m_inc_s2[i];
        dp = m_dec_s1[i] && !m_dec_s2[i];
        if (ip && !dp)      m_target[i] = (m_target[i] + STEP > PERIOD) ? PERIOD : m_target[i] + STEP;
        else if (dp && !ip) m_target[i] = (m_target[i] >= STEP) ? m_target[i] - STEP : 0;
        m_inc_s2[i] = m_inc_s1[i]; m_inc_s1[i] = inc_btn[i];
        m_dec_s2[i] = m_dec_s1[i]; m_dec_s1[i] = dec_btn[i];
      end
    end
    m_tick = (m_tick + 1) % DEB_DIV;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("pwm_out", 64'(pwm_out), 64'(exp_pwm()));
    chk("duty_out", 64'(duty_out), 64'(exp_duty()));
    chk("period_start", 64'(period_start), 64'(m_ps));
  endtask

  initial begin
    logic [CHANNELS*CNT_W-1:0] rst_duty;
    rst_duty = '0;
    for (int i = 0; i < CHANNELS; i++) rst_duty[i*CNT_W +: CNT_W] = CNT_W'(DUTY_RESET);

    rst = 1'b1; en = 1'b0; inc_btn = '0; dec_btn = '0;
    @(negedge clk);
    cycle();
    cycle();
    chk("reset_pwm", 64'(pwm_out), 64'(0));
    chk("reset_duty", 64'(duty_out), 64'(rst_duty));
    chk("reset_ps", 64'(period_start), 64'(0));

    rst = 1'b0; en = 1'b1;
    repeat (40) cycle();

    // Single long hold: only one press
    inc_btn[0] = 1'b1;
    repeat (20) cycle();
    inc_btn[0] = 1'b0;
    repeat (30) cycle();

    // Many inc presses on channel 0 to saturate at PERIOD
    for (int k = 0; k < 300; k++) begin
      inc_btn[0] = ((k / 4) % 2) != 0;
      cycle();
    end
    inc_btn[0] = 1'b0;
    repeat (2 * PLEN + 4) cycle();
    chk("sat_hi_duty", 64'(duty_out[CNT_W-1:0]), 64'(PERIOD));
    for (int k = 0; k < PLEN + 2; k++) begin
      cycle();
      chk("sat_hi_pwm", 64'(pwm_out[0]), 64'(1));
    end

    // Many dec presses down to 0
    for (int k = 0; k < 300; k++) begin
      dec_btn[0] = ((k / 4) % 2) != 0;
      cycle();
    end
    dec_btn[0] = 1'b0;
    repeat (2 * PLEN + 4) cycle();
    chk("sat_lo_duty", 64'(duty_out[CNT_W-1:0]), 64'(0));
    for (int k = 0; k < PLEN + 2; k++) begin
      cycle();
      chk("sat_lo_pwm", 64'(pwm_out[0]), 64'(0));
    end

    // Simultaneous inc and dec cancel
    for (int k = 0; k < 100; k++) begin
      inc_btn[0] = ((k / 4) % 2) != 0;
      dec_btn[0] = inc_btn[0];
      cycle();
    end
    inc_btn = '0; dec_btn = '0;
    repeat (2 * PLEN + 4) cycle();
    chk("both_duty", 64'(duty_out[CNT_W-1:0]), 64'(0));

    // en dropped for a while, then resumed
    en = 1'b0;
    repeat (7) cycle();
    chk("en_off_pwm", 64'(pwm_out), 64'(0));
    en = 1'b1;
    repeat (30) cycle();

    // Randomized run
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(7) == 0) inc_btn[$urandom_range(CHANNELS-1)] ^= 1'b1;
      if ($urandom_range(7) == 0) dec_btn[$urandom_range(CHANNELS-1)] ^= 1'b1;
      if ($urandom_range(19) == 0) en = ~en;
      rst = ($urandom_range(499) == 0);
      cycle();
    end
    rst = 1'b0; en = 1'b1;
    repeat (13) cycle();

    // Reset mid-period
    rst = 1'b1;
    cycle();
    chk("midrst_pwm", 64'(pwm_out), 64'(0));
    chk("midrst_duty", 64'(duty_out), 64'(rst_duty));
    chk("midrst_ps", 64'(period_start), 64'(0));
    rst = 1'b0;
    repeat (2 * PLEN) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
